// File: rtl/ram_1h_loader_pkg.sv
// Shared state encoding and default geometry for the RAM loader.
package ram_1h_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_1h_loader.sv
// Front end for a single-port RAM: CPU pass-through when idle, otherwise the
// block owns the RAM to fill it with a constant or load it from a stream.
module ram_1h_loader
  import ram_1h_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  input  logic                  load_req,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  input  logic                  dl_valid,
  input  logic [DATA_WIDTH-1:0] dl_data,
  input  logic                  dl_last,
  output logic                  dl_ready,
  input  logic                  cpu_en,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [DATA_WIDTH-1:0] cpu_q,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  output logic                  ram_clken,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [1:0]            state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]   ld_cnt_q, ld_cnt_d;
  logic                    pend_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;
  logic [DATA_WIDTH-1:0]   pend_data_q;
  logic                    overflow_q, busy_q, done_q, ready_q;

  // Both counters wrap naturally at the top of the address space.
  assign clr_cnt_d = clr_cnt_q + 1'b1;
  assign ld_cnt_d  = ld_cnt_q + 1'b1;

  // Handshake: a download beat transfers on a rising edge where dl_valid and
  // dl_ready are both high; dl_ready is high only while in LOAD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      ld_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end else if (load_req) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            ready_q    <= 1'b1;
            ld_cnt_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == ADDR_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (dl_valid && ready_q) begin
            pend_q      <= 1'b1;
            pend_addr_q <= ld_cnt_q;
            pend_data_q <= dl_data;
            ld_cnt_q    <= ld_cnt_d;
            if (ld_cnt_q == ADDR_LAST) overflow_q <= 1'b1;
            if (dl_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // While busy the loader alone drives the RAM; the last load write lands in DONE.
  always_comb begin
    ram_address = cpu_addr;
    ram_data    = cpu_data;
    ram_wren    = cpu_we & cpu_en;
    ram_clken   = cpu_en;
    case (state_q)
      ST_CLEAR: begin
        ram_address = clr_cnt_q;
        ram_data    = FILL_VALUE;
        ram_wren    = 1'b1;
        ram_clken   = 1'b1;
      end
      ST_LOAD, ST_DONE: begin
        ram_address = pend_addr_q;
        ram_data    = pend_data_q;
        ram_wren    = pend_q;
        ram_clken   = pend_q;
      end
      default: ;
    endcase
  end

  assign cpu_q     = ram_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign dl_ready  = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_1h_loader.sv
// Bench for ram_1h_loader: behavioural RAM, a write scoreboard and a memory model.
module tb_ram_1h_loader;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + DW;
  localparam logic [DW-1:0] FILL = 8'h00;

  localparam int M_IDLE = 0, M_CLR = 1, M_CDONE = 2, M_LOAD = 3, M_LDONE = 4, M_POST = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear_req, load_req;
  logic          busy, done, overflow;
  logic          dl_valid, dl_last, dl_ready;
  logic [DW-1:0] dl_data;
  logic          cpu_en, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data, cpu_q;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, ram_clken;
  logic [1:0]    state_dbg;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic [W-1:0]  exp_q[$];

  int total = 0;
  int bad = 0;
  int mode = M_IDLE;
  int beat_cnt = 0;
  int clr_idx = 0;
  bit ovf_check = 1'b0;

  ram_1h_loader dut (
    .clock(clock), .reset_n(reset_n),
    .clear_req(clear_req), .load_req(load_req),
    .busy(busy), .done(done), .overflow(overflow),
    .dl_valid(dl_valid), .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_q(cpu_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_clken(ram_clken), .ram_q(ram_q), .state_dbg(state_dbg)
  );

  // ---------------- clock / RAM ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_clken) begin
      if (ram_wren) ram[ram_address] <= ram_data;
      ram_q <= ram[ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [W-1:0] e;
    case (mode)
      M_CLR: begin
        check("clear_write", {busy, done, ram_wren, ram_clken, ram_address, ram_data},
              {1'b1, 1'b0, 1'b1, 1'b1, clr_idx[AW-1:0], FILL});
        clr_idx++;
        if (clr_idx == DEPTH) mode = M_CDONE;
      end
      M_CDONE: begin
        check("clear_done", {busy, done, ram_wren}, 3'b110);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
        ovf_check = 1'b0;
        mode = M_POST;
      end
      M_LOAD, M_LDONE: begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("load_write", {ram_wren, ram_clken, ram_address, ram_data}, {2'b11, e});
        end else begin
          check("no_write", {ram_wren, ram_clken}, 2'b00);
        end
        if (mode == M_LDONE) begin
          check("load_done", {busy, done, dl_ready}, 3'b110);
          ovf_check = 1'b1;
          mode = M_POST;
        end else begin
          check("load_ready", {busy, done, dl_ready}, 3'b101);
          if (dl_valid) begin
            exp_q.push_back({AW'(beat_cnt % DEPTH), dl_data});
            model_mem[beat_cnt % DEPTH] = dl_data;
            beat_cnt++;
            if (dl_last) mode = M_LDONE;
          end
        end
      end
      M_POST: begin
        check("post_idle", {busy, done, dl_ready}, 3'b000);
        if (ovf_check) check("overflow", overflow, (beat_cnt >= DEPTH));
        mode = M_IDLE;
      end
      default: ;
    endcase
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
    model_mem[a] = d;
    @(posedge clock); #1;
    cpu_en = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clock); #1;
    cpu_en = 1'b0;
    check("cpu_read", cpu_q, model_mem[a]);
  endtask

  task automatic start_clear(input logic with_load);
    clear_req = 1'b1; load_req = with_load;
    @(posedge clock); #1;
    clear_req = 1'b0; load_req = 1'b0;
    clr_idx = 0;
    mode = M_CLR;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
    beat_cnt = 0;
    exp_q.delete();
    mode = M_LOAD;
  endtask

  // Random requests and CPU writes ride along with beats; the DUT must ignore them.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic noise);
    dl_valid = 1'b1; dl_data = d; dl_last = last;
    if (noise) begin
      clear_req = 1'($urandom_range(0, 1));
      load_req  = 1'($urandom_range(0, 1));
      cpu_en    = 1'($urandom_range(0, 1));
      cpu_we    = 1'b1;
      cpu_addr  = AW'($urandom);
      cpu_data  = DW'($urandom);
    end
    @(posedge clock); #1;
    dl_valid = 1'b0; dl_last = 1'b0;
    clear_req = 1'b0; load_req = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int c = 0; c < limit; c++) begin
      @(posedge clock); #1;
      if (mode == M_IDLE) break;
    end
    check("op_timeout", mode, M_IDLE);
    if (mode != M_IDLE) begin
      mode = M_IDLE;
      exp_q.delete();
      reset_n = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(1);
    end
  endtask

  typedef struct {
    logic          en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_wren, exp_clken;
  } pt_vec_t;

  pt_vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 11'h005, 8'h11, 11'h005, 8'h11, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 11'h7FF, 8'h22, 11'h7FF, 8'h22, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 11'h123, 8'h33, 11'h123, 8'h33, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 11'h000, 8'h00, 11'h000, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 11'h7FF, 8'h44, 11'h7FF, 8'h44, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 11'h000, 8'h55, 11'h000, 8'h55, 1'b1, 1'b1};

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = DW'($urandom);
      model_mem[i] = ram[i];
    end
    reset_n = 1'b0;
    clear_req = 1'b0; load_req = 1'b0;
    dl_valid = 1'b0; dl_data = '0; dl_last = 1'b0;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;

    // Reset values
    cycles(3);
    check("reset_outputs", {busy, done, overflow, dl_ready, state_dbg}, 6'b0);
    reset_n = 1'b1;
    cycles(1);
    check("after_reset", {busy, done, overflow, dl_ready, state_dbg}, 6'b0);

    // IDLE pass-through table
    for (int i = 0; i < 6; i++) begin
      cpu_en = vecs[i].en; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_data = vecs[i].data;
      #1;
      check("passthrough", {ram_address, ram_data, ram_wren, ram_clken},
            {vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_wren, vecs[i].exp_clken});
      if (vecs[i].en && vecs[i].we) model_mem[vecs[i].addr] = vecs[i].data;
      @(posedge clock); #1;
    end
    cpu_en = 1'b0; cpu_we = 1'b0;
    cpu_read(11'h005);
    cpu_read(11'h7FF);
    cpu_read(11'h000);

    // Clear with a simultaneous load request, CPU write during clear is dropped
    start_clear(1'b1);
    cycles(20);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_data = 8'h77;
    cycles(1);
    cpu_en = 1'b0; cpu_we = 1'b0;
    wait_idle(DEPTH + 20);
    check("clear_count", clr_idx, DEPTH);
    cpu_read(11'h000);
    cpu_read(11'h7FF);
    cpu_read(11'h010);

    // Three-beat load
    start_load();
    send_beat(8'hA5, 1'b0, 1'b0);
    send_beat(8'h5A, 1'b0, 1'b0);
    send_beat(8'h3C, 1'b1, 1'b0);
    wait_idle(20);
    check("ram0_a5", ram[0], 8'hA5);
    for (int a = 0; a < 3; a++) cpu_read(AW'(a));

    // Mid-stream gap of five cycles with noise on the request lines
    start_load();
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      clear_req = 1'b1; cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_data = 8'hEE;
      cycles(1);
    end
    clear_req = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0;
    send_beat(8'h03, 1'b0, 1'b0);
    send_beat(8'h04, 1'b1, 1'b0);
    wait_idle(20);
    for (int a = 0; a < 4; a++) cpu_read(AW'(a));
    cpu_read(11'h020);

    // Wrap: DEPTH+1 beats
    start_load();
    for (int b = 0; b <= DEPTH; b++) send_beat(DW'($urandom), (b == DEPTH), 1'b0);
    wait_idle(20);
    check("overflow_wrap", overflow, 1'b1);
    cpu_read(11'h000);
    cpu_read(11'h001);
    cpu_read(11'h002);
    cpu_read(11'h400);
    cpu_read(11'h7FF);

    // Random loads, gaps and noise
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 12);
      start_load();
      for (int b = 0; b < len; b++) begin
        cycles($urandom_range(0, 3));
        send_beat(DW'($urandom), (b == len - 1), 1'b1);
      end
      wait_idle(20);
      check("overflow_short", overflow, 1'b0);
      cycles($urandom_range(0, 2));
    end
    for (int k = 0; k < 10; k++) cpu_write(AW'($urandom_range(0, 31)), DW'($urandom));
    for (int k = 0; k < 16; k++) cpu_read(AW'($urandom_range(0, 31)));

    // Reset in the middle of a load
    start_load();
    send_beat(8'hE1, 1'b0, 1'b0);
    send_beat(8'hE2, 1'b0, 1'b0);
    send_beat(8'hE3, 1'b0, 1'b0);
    @(posedge clock); #1;
    mode = M_IDLE;
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check("async_reset", {busy, done, overflow, dl_ready, state_dbg}, 6'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cycles(1);
    check("idle_after_reset", {busy, state_dbg}, 3'b000);
    cpu_write(11'h100, 8'h9A);
    cpu_read(11'h100);
    for (int a = 0; a < 3; a++) cpu_read(AW'(a));
    check("retained_e3", ram[2], 8'hE3);

    // Whole-memory agreement with the model
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_mem[i]) diffs++;
      check("mem_image", diffs, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_1h_loader.md
RAM_1H_LOADER -- requirements
Module: ram_1h_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, RAM address width; the RAM depth is 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 The block SHALL have parameter FILL_VALUE, default 0, the word written by a clear.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clock (in, 1) is the sole clock; reset_n (in, 1) is the asynchronous active-low reset.
REQ-005 The block SHALL have the following requester ports:
- clear_req (in, 1): start a clear.
- load_req (in, 1): start a load.
- busy (out, 1): loader owns the RAM.
- done (out, 1): one-cycle completion pulse.
- overflow (out, 1): sticky flag; load counter wrapped.
REQ-006 The block SHALL have a download stream: dl_valid (in, 1), dl_data (in, DATA_WIDTH), dl_last (in, 1), dl_ready (out, 1).
REQ-007 The block SHALL have a CPU side:
- cpu_en (in, 1), cpu_we (in, 1).
- cpu_addr (in, ADDR_WIDTH), cpu_data (in, DATA_WIDTH).
- cpu_q (out, DATA_WIDTH).
REQ-008 The block SHALL have a RAM side that drives the single-port RAM:
- ram_address (out, ADDR_WIDTH), ram_data (out, DATA_WIDTH).
- ram_wren (out, 1), ram_clken (out, 1).
- ram_q (in, DATA_WIDTH).

Function
REQ-009 The block SHALL have states IDLE, CLEAR, LOAD and DONE.
REQ-010 IDLE SHALL pass the CPU through combinationally: ram_address=cpu_addr, ram_data=cpu_data, ram_wren=cpu_we&cpu_en, ram_clken=cpu_en.
REQ-011 cpu_q SHALL equal ram_q in every state; read latency is 1 cycle, set by the RAM.
REQ-012 In IDLE, clear_req SHALL transition to CLEAR; clear_req has priority over a simultaneous load_req, and that load_req is ignored.
REQ-013 In IDLE, load_req without clear_req SHALL transition to LOAD.
REQ-014 In CLEAR, the block SHALL drive ram_clken=1, ram_wren=1 and ram_data=FILL_VALUE every cycle.
REQ-015 In CLEAR, ram_address SHALL come from a registered counter running 0 to 2**ADDR_WIDTH-1.
REQ-016 CLEAR SHALL transition to DONE after the write to the last address; clearing takes exactly 2**ADDR_WIDTH cycles.
REQ-017 In LOAD, dl_ready SHALL be 1; dl_ready is 0 in all other states.
REQ-018 In LOAD, a beat SHALL be accepted on dl_valid&dl_ready.
REQ-019 Each accepted beat SHALL register its data and the load counter, and SHALL drive a write (ram_wren=ram_clken=1) in the following cycle; write latency is 1 cycle after acceptance.
REQ-020 In LOAD, the block SHALL drive ram_wren=ram_clken=0 in cycles with no pending registered write.
REQ-021 The load counter SHALL start at 0 on entry to LOAD and increment by 1 per accepted beat.
REQ-022 A beat accepted at counter 2**ADDR_WIDTH-1 SHALL be written there, wrap the counter to 0, and set overflow; overflow clears only on the next entry to LOAD or on reset.
REQ-023 An accepted beat with dl_last=1 SHALL transition to DONE; its write is issued in the DONE cycle.
REQ-024 dl_valid=0 in LOAD SHALL hold state indefinitely with no write.
REQ-025 In DONE, the block SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in CLEAR, LOAD and DONE.
REQ-027 In CLEAR, LOAD and DONE, CPU writes SHALL be dropped and the RAM side is driven only by the loader.
REQ-028 clear_req and load_req SHALL be ignored while busy=1.

Reset
REQ-029 reset_n low SHALL asynchronously force:
- state to IDLE.
- both counters and the pending-write register to 0.
- overflow=0, done=0, busy=0, dl_ready=0.
REQ-030 Reset mid-CLEAR or mid-LOAD SHALL abandon the operation; RAM contents already written stay as written.
REQ-031 The block SHALL leave reset synchronously to the clock, with the first state change no earlier than the first rising edge after reset_n rises.

Structure
REQ-032 The state encoding and the default width constants SHALL live in a shared package; no other typedefs are needed.
REQ-033 The block SHALL be a single module with no sub-modules; the RAM is instantiated by the parent, not inside this block.

Verification
REQ-034 Clear: with ADDR_WIDTH=11 and FILL_VALUE=0x00, pulse clear_req -> 2048 consecutive writes to addresses 0..2047, then done high for 1 cycle; CPU reads of 0x000 and 0x7FF return 0x00.
REQ-035 Load: pulse load_req, stream 0xA5, 0x5A, 0x3C with the last beat flagged -> RAM[0..2]=A5,5A,3C, each write 1 cycle after acceptance, done once, overflow=0.
REQ-036 Backpressure/gaps: a dl_valid gap of 5 cycles mid-stream -> no spurious writes and the counter holds.
REQ-037 Wrap: stream 2049 beats, the last flagged -> overflow=1, RAM[0] holds beat 2048, RAM[1..2047] hold beats 1..2047.
REQ-038 Priority/drop: clear_req and load_req in the same cycle -> CLEAR entered; a CPU write of 0x77 to 0x010 during CLEAR is dropped and reads 0x00 afterwards.
REQ-039 Reset mid-load: reset_n low after 3 beats -> immediately IDLE, busy=0; after release the CPU pass-through works and RAM[0..2] are retained.
